// File: rtl/fpu_pkg.sv
// Shared opcode encodings, opcode classifiers and controller FSM states for the
// FPU issue front end.
package fpu_pkg;

  localparam logic [3:0] FP_ADD   = 4'b0000;
  localparam logic [3:0] FP_SUB   = 4'b0001;
  localparam logic [3:0] FP_MAX   = 4'b0010;
  localparam logic [3:0] FP_MUL   = 4'b0011;
  localparam logic [3:0] FP_MIN   = 4'b0100;
  localparam logic [3:0] FP_ABS   = 4'b0101;
  localparam logic [3:0] FP_NEG   = 4'b0110;
  localparam logic [3:0] FP_FLOOR = 4'b1000;
  localparam logic [3:0] FP_CEIL  = 4'b1001;
  localparam logic [3:0] FP_SIGN  = 4'b1010;
  localparam logic [3:0] FP_IDLE  = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } fsm_state_e;

  function automatic logic is_mul(input logic [3:0] op);
    return op == FP_MUL;
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    logic legal;
    case (op)
      FP_ADD, FP_SUB, FP_MAX, FP_MUL, FP_MIN, FP_ABS,
      FP_NEG, FP_FLOOR, FP_CEIL, FP_SIGN: legal = 1'b1;
      default:                            legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Request, FPU-drive and response signals of one FPU issue controller.
// slave: the controller; master: core dispatch, FPU and response consumer.
interface fpu_issue_ctrl_if #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned TAG_W = 4
);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [3:0]       req_op;
  logic [TAG_W-1:0] req_tag;

  logic [WIDTH-1:0] fpu_a;
  logic [WIDTH-1:0] fpu_b;
  logic [3:0]       fpu_op;
  logic [WIDTH-1:0] fpu_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_tag,
    output req_ready,
    output fpu_a, fpu_b, fpu_op,
    input  fpu_result,
    output rsp_valid, rsp_result, rsp_tag, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_a, req_b, req_op, req_tag,
    input  req_ready,
    input  fpu_a, fpu_b, fpu_op,
    output fpu_result,
    input  rsp_valid, rsp_result, rsp_tag, rsp_err,
    output rsp_ready
  );

endinterface

// File: rtl/fpu_req_fifo.sv
// Synchronous request FIFO holding packed {tag, op, b, a} entries; head is
// presented combinationally, pointers wrap modulo DEPTH (power of two).
module fpu_req_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  output logic          ready_o,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Simultaneous push and pop leave the occupancy unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign ready_o = count_q < CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: queues tagged requests, drives one op at a time into the
// FPU, captures its result and returns it in order. Build option
// FPU_ISSUE_OPCHECK_EN suppresses illegal opcodes and flags them on rsp_err.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned WIDTH   = 24,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned MUL_LAT = 1
) (
  input logic             clk,
  input logic             rst,
  fpu_issue_ctrl_if.slave bus
);

  localparam int unsigned DW    = TAG_W + 4 + 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);

  logic             push_c;
  logic             ready_c;
  logic             empty_c;
  logic [DW-1:0]    wdata_c;
  logic [DW-1:0]    head_c;
  logic [WIDTH-1:0] head_a_c;
  logic [WIDTH-1:0] head_b_c;
  logic [3:0]       head_op_c;
  logic [TAG_W-1:0] head_tag_c;
  logic             illegal_c;
  logic             capture_c;
  logic             issue_c;
  logic [3:0]       issue_op_c;

  fsm_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] fpu_a_q;
  logic [WIDTH-1:0] fpu_b_q;
  logic [3:0]       fpu_op_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic             rsp_err_q;

  assign wdata_c = {bus.req_tag, bus.req_op, bus.req_b, bus.req_a};
  assign {head_tag_c, head_op_c, head_b_c, head_a_c} = head_c;
  assign push_c = bus.req_valid & ready_c;

  fpu_req_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .data_i  (wdata_c),
    .ready_o (ready_c),
    .pop_i   (capture_c),
    .data_o  (head_c),
    .empty_o (empty_c)
  );

  // Head classification; a MUL waits for its latency counter to drain.
  always_comb begin
    illegal_c = 1'b0;
`ifdef FPU_ISSUE_OPCHECK_EN
    illegal_c = !is_legal(head_op_c);
`endif
    issue_op_c = illegal_c ? FP_IDLE : head_op_c;
    capture_c  = (state_q == S_EXEC) && (!is_mul(head_op_c) || (cnt_q == '0));
    issue_c    = !empty_c &&
                 ((state_q == S_IDLE) || ((state_q == S_RESP) && bus.rsp_ready));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      fpu_a_q      <= '0;
      fpu_b_q      <= '0;
      fpu_op_q     <= FP_IDLE;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      // Operands latch from the head on entry to EXEC and hold until capture.
      if (issue_c) begin
        fpu_a_q  <= illegal_c ? '0 : head_a_c;
        fpu_b_q  <= illegal_c ? '0 : head_b_c;
        fpu_op_q <= issue_op_c;
        cnt_q    <= CNT_W'(MUL_LAT);
      end
      case (state_q)
        S_IDLE: begin
          if (issue_c) state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (capture_c) begin
            state_q      <= S_RESP;
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= illegal_c ? '0 : bus.fpu_result;
            rsp_tag_q    <= head_tag_c;
            rsp_err_q    <= illegal_c;
            fpu_a_q      <= '0;
            fpu_b_q      <= '0;
            fpu_op_q     <= FP_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= issue_c ? S_EXEC : S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = ready_c;
  assign bus.fpu_a      = fpu_a_q;
  assign bus.fpu_b      = fpu_b_q;
  assign bus.fpu_op     = fpu_op_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: directed latency/backpressure/reset/illegal-op steps
// followed by random traffic, scored against an in-order response queue.
module tb_fpu_issue_ctrl;

  localparam int unsigned W       = 24;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TW      = 4;
  localparam int unsigned MUL_LAT = 1;
`ifdef FPU_ISSUE_OPCHECK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [W-1:0]  res;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  logic [W-1:0] mul_pipe [MUL_LAT];

  always #5 clk = ~clk;

  fpu_issue_ctrl_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  fpu_issue_ctrl #(
    .WIDTH   (W),
    .DEPTH   (DEPTH),
    .TAG_W   (TW),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Arbitrary but distinct per-opcode arithmetic standing in for the FPU.
  function automatic logic [W-1:0] fpu_model(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W-1:0]   msb;
    logic [2*W-1:0] p;
    msb = W'(1) << (W - 1);
    p   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h2:    return (a > b) ? a : b;
      4'h3:    return p[W-1:0];
      4'h4:    return (a < b) ? a : b;
      4'h5:    return a & ~msb;
      4'h6:    return a ^ msb;
      4'h8:    return a & ~W'(8'hFF);
      4'h9:    return a | W'(8'hFF);
      4'hA:    return a[W-1] ? msb : W'(1);
      default: return '0;
    endcase
  endfunction

  function automatic bit op_legal(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA};
  endfunction

  // FPU stand-in: MUL result appears MUL_LAT cycles after its operands.
  always @(posedge clk) begin
    mul_pipe[0] <= fpu_model(4'h3, bus.fpu_a, bus.fpu_b);
    for (int i = 1; i < int'(MUL_LAT); i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign bus.fpu_result = (bus.fpu_op == 4'h3) ? mul_pipe[MUL_LAT-1]
                                               : fpu_model(bus.fpu_op, bus.fpu_a, bus.fpu_b);

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Monitor: records accepted requests, scores responses in order, checks hold.
  logic          hold_q = 1'b0;
  logic [W-1:0]  hold_res;
  logic [TW-1:0] hold_tag;
  logic          hold_err;
  exp_t          mon_e;
  always begin
    @(negedge clk);
    #3;
    if (rst) begin
      exp_q.delete();
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        chk("hold_valid", 64'(bus.rsp_valid), 64'(1'b1));
        chk("hold_result", 64'(bus.rsp_result), 64'(hold_res));
        chk("hold_tag", 64'(bus.rsp_tag), 64'(hold_tag));
        chk("hold_err", 64'(bus.rsp_err), 64'(hold_err));
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(bus.rsp_valid), 64'(1'b0));
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_tag", 64'(bus.rsp_tag), 64'(mon_e.tag));
          chk("rsp_result", 64'(bus.rsp_result), 64'(mon_e.res));
          chk("rsp_err", 64'(bus.rsp_err), 64'(mon_e.err));
        end
      end
`ifdef FPU_ISSUE_OPCHECK_EN
      chk("fpu_op_legal", 64'(op_legal(bus.fpu_op) || (bus.fpu_op == 4'hF)), 64'(1'b1));
`endif
      if (bus.req_valid && bus.req_ready) begin
        mon_e.tag = bus.req_tag;
        mon_e.res = fpu_model(bus.req_op, bus.req_a, bus.req_b);
        mon_e.err = OPCHK && !op_legal(bus.req_op);
        exp_q.push_back(mon_e);
      end
      hold_q   = bus.rsp_valid && !bus.rsp_ready;
      hold_res = bus.rsp_result;
      hold_tag = bus.rsp_tag;
      hold_err = bus.rsp_err;
    end
  end

  task automatic drive_req(input logic [3:0] op, input logic [TW-1:0] tag,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_tag   = tag;
    bus.req_a     = a;
    bus.req_b     = b;
  endtask

  logic [3:0]   add_ops [9] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA};
  logic [W-1:0] fill_exp [5];
  logic [W-1:0] ra, rb;
  logic [3:0]   rop;
  int           pushed;
  int           budget;

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    bus.req_tag = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) cyc();
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(1'b0));
    chk("rst_rsp_result", 64'(bus.rsp_result), 64'(0));
    chk("rst_rsp_tag", 64'(bus.rsp_tag), 64'(0));
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'(1'b0));
    chk("rst_fpu_a", 64'(bus.fpu_a), 64'(0));
    chk("rst_fpu_b", 64'(bus.fpu_b), 64'(0));
    chk("rst_fpu_op", 64'(bus.fpu_op), 64'(4'hF));
    rst = 1'b0;
    cyc();
    chk("rst_req_ready", 64'(bus.req_ready), 64'(1'b1));

    // Single ADD, accepted in cycle 0.
    drive_req(4'h0, 4'd3, 24'h3F8000, 24'h400000);
    chk("add_accept", 64'(bus.req_ready), 64'(1'b1));
    cyc();
    bus.req_valid = 1'b0;
    chk("add_c1_op", 64'(bus.fpu_op), 64'(4'hF));
    cyc();
    chk("add_c2_op", 64'(bus.fpu_op), 64'(4'h0));
    chk("add_c2_a", 64'(bus.fpu_a), 64'(24'h3F8000));
    chk("add_c2_b", 64'(bus.fpu_b), 64'(24'h400000));
    chk("add_c2_valid", 64'(bus.rsp_valid), 64'(1'b0));
    cyc();
    chk("add_c3_valid", 64'(bus.rsp_valid), 64'(1'b1));
    chk("add_c3_tag", 64'(bus.rsp_tag), 64'(4'd3));
    chk("add_c3_result", 64'(bus.rsp_result), 64'(fpu_model(4'h0, 24'h3F8000, 24'h400000)));
    chk("add_c3_op_idle", 64'(bus.fpu_op), 64'(4'hF));
    cyc();
    chk("add_c4_valid", 64'(bus.rsp_valid), 64'(1'b0));

    // MUL: opcode held MUL_LAT+1 cycles, response in cycle 3+MUL_LAT.
    ra = W'($urandom()) | W'(1);
    rb = W'($urandom()) | W'(1);
    drive_req(4'h3, 4'd5, ra, rb);
    cyc();
    bus.req_valid = 1'b0;
    chk("mul_c1_op", 64'(bus.fpu_op), 64'(4'hF));
    for (int k = 0; k <= int'(MUL_LAT); k++) begin
      cyc();
      chk("mul_exec_op", 64'(bus.fpu_op), 64'(4'h3));
      chk("mul_exec_valid", 64'(bus.rsp_valid), 64'(1'b0));
    end
    cyc();
    chk("mul_valid", 64'(bus.rsp_valid), 64'(1'b1));
    chk("mul_tag", 64'(bus.rsp_tag), 64'(4'd5));
    chk("mul_result", 64'(bus.rsp_result), 64'(fpu_model(4'h3, ra, rb)));
    cyc();

    // Fill with the consumer stalled, then hold RESP under backpressure.
    bus.rsp_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      rop = add_ops[$urandom_range(0, 8)];
      ra  = W'($urandom());
      rb  = W'($urandom());
      fill_exp[t] = fpu_model(rop, ra, rb);
      drive_req(rop, TW'(t), ra, rb);
      budget = 0;
      while (!bus.req_ready && budget < 50) begin
        cyc();
        budget++;
      end
      chk("fill_ready", 64'(bus.req_ready), 64'(1'b1));
      cyc();
    end
    bus.req_valid = 1'b0;
    cyc();
    chk("full_ready_low", 64'(bus.req_ready), 64'(1'b0));
    chk("full_rsp_valid", 64'(bus.rsp_valid), 64'(1'b1));
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("bp_tag", 64'(bus.rsp_tag), 64'(0));
      chk("bp_result", 64'(bus.rsp_result), 64'(fill_exp[0]));
      chk("bp_no_pop", 64'(bus.req_ready), 64'(1'b0));
    end
    bus.rsp_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      cyc();
      chk("drain_exec_gap", 64'(bus.rsp_valid), 64'(1'b0));
      cyc();
      chk("drain_valid", 64'(bus.rsp_valid), 64'(1'b1));
      chk("drain_tag", 64'(bus.rsp_tag), 64'(k));
      chk("drain_result", 64'(bus.rsp_result), 64'(fill_exp[k]));
    end
    cyc();
    chk("drain_done", 64'(bus.rsp_valid), 64'(1'b0));
    chk("drain_ready", 64'(bus.req_ready), 64'(1'b1));

    // Async reset in the EXEC of a MUL with another request queued behind it.
    drive_req(4'h3, 4'd9, W'($urandom()) | W'(1), W'($urandom()) | W'(1));
    cyc();
    drive_req(4'h0, 4'd10, W'($urandom()), W'($urandom()));
    cyc();
    bus.req_valid = 1'b0;
    chk("rstmid_exec_op", 64'(bus.fpu_op), 64'(4'h3));
    #1 rst = 1'b1;
    #1;
    chk("rstmid_valid", 64'(bus.rsp_valid), 64'(1'b0));
    chk("rstmid_op", 64'(bus.fpu_op), 64'(4'hF));
    chk("rstmid_ready", 64'(bus.req_ready), 64'(1'b1));
    cyc();
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("rstmid_quiet_valid", 64'(bus.rsp_valid), 64'(1'b0));
      chk("rstmid_quiet_op", 64'(bus.fpu_op), 64'(4'hF));
    end

    // Illegal opcode 1100.
    drive_req(4'hC, 4'd7, W'($urandom()) | W'(1), W'($urandom()) | W'(1));
    cyc();
    bus.req_valid = 1'b0;
    cyc();
    chk("illegal_exec_op", 64'(bus.fpu_op), 64'(OPCHK ? 4'hF : 4'hC));
    cyc();
    chk("illegal_valid", 64'(bus.rsp_valid), 64'(1'b1));
    chk("illegal_tag", 64'(bus.rsp_tag), 64'(4'd7));
    chk("illegal_result", 64'(bus.rsp_result), 64'(0));
    chk("illegal_err", 64'(bus.rsp_err), 64'(OPCHK));
    cyc();

    // Random traffic with random consumer backpressure.
    pushed = 0;
    budget = 0;
    while (pushed < 60 && budget < 3000) begin
      if (!bus.req_valid || bus.req_ready) begin
        drive_req(4'($urandom_range(0, 15)), TW'($urandom()),
                  W'($urandom()) | W'(1), W'($urandom()) | W'(1));
        bus.req_valid = ($urandom_range(0, 3) != 0);
      end
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
      if (bus.req_valid && bus.req_ready) pushed++;
      cyc();
      budget++;
    end
    chk("rand_pushed", 64'(pushed), 64'(60));
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    budget = 0;
    while ((exp_q.size() != 0 || bus.rsp_valid) && budget < 500) begin
      cyc();
      budget++;
    end
    chk("rand_drain_queue", 64'(exp_q.size()), 64'(0));
    chk("rand_drain_valid", 64'(bus.rsp_valid), 64'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Requester-side front end for the shader core's FPU datapath.
- Buffers tagged operation requests from the core in a small FIFO and drives operands and opcode into the FPU.
- Holds the opcode stable for the multiplier's registered latency, captures the result, and returns it in order on a valid/ready response channel.
- Sits between the core's ALU dispatch and the FPU instance, one controller per FPU.

Parameters:
- WIDTH, 24, floating-point word width (operands and result).
- DEPTH, 4, request FIFO entries; power of two, ≥2.
- TAG_W, 4, request tag width, echoed on the response.
- MUL_LAT, 1, cycles from fpu_op=MUL until fpu_result is valid; ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- req_op  in  4  FPU opcode
- req_tag  in  TAG_W  request tag
- fpu_a  out  WIDTH  operand A to FPU
- fpu_b  out  WIDTH  operand B to FPU
- fpu_op  out  4  opcode to FPU
- fpu_result  in  WIDTH  FPU result
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer ready
- rsp_result  out  WIDTH  captured result
- rsp_tag  out  TAG_W  tag of the request that produced the result
- rsp_err  out  1  illegal opcode flag (see Optional Feature)

Behaviour:
- Reset (async, rst=1):
  - FIFO empty; FSM in IDLE.
  - rsp_valid=0, rsp_result=0, rsp_tag=0, rsp_err=0.
  - fpu_a=0, fpu_b=0, fpu_op=4'hF (idle opcode; FPU outputs 0).
  - req_ready=1 after reset deasserts.
- FIFO:
  - req_ready = (count < DEPTH).
  - Push when req_valid&req_ready.
  - Pop only on result capture.
  - A push and a pop in the same cycle keep count unchanged.
  - When full, req_ready stays 0 even if a pop occurs that cycle; no bypass.
  - Pointers wrap modulo DEPTH.
- Opcode classes:
  - ADD class (0000, 0001, 0010, 0100), ABS (0101), NEG (0110), FLOOR (1000), CEIL (1001), SIGN (1010): combinational, result valid in the same cycle.
  - MUL (0011): valid MUL_LAT cycles after issue.
  - Illegal: 0111, 1011–1111.
- FSM states IDLE, EXEC, RESP:
  - IDLE: fpu_op=4'hF. Go to EXEC next cycle if FIFO non-empty. A request pushed in cycle N is seen as non-empty in N+1.
  - EXEC: fpu_a, fpu_b, fpu_op driven from the FIFO head and held stable for the whole state.
    - Combinational op: capture fpu_result into rsp_result on the first EXEC cycle.
    - MUL: a down-counter loaded with MUL_LAT; capture on the cycle after it reaches 0.
    - On capture: pop the FIFO, latch rsp_tag, go to RESP.
  - RESP: rsp_valid=1; rsp_result, rsp_tag, rsp_err held stable until rsp_ready. On handshake go to EXEC if FIFO non-empty, else IDLE. fpu_op=4'hF.
- Latency from request acceptance in cycle 0, empty FIFO, rsp_ready=1:
  - Combinational op: rsp_valid in cycle 3.
  - MUL: rsp_valid in cycle 3+MUL_LAT.
- Throughput: back-to-back combinational ops complete one per 2 cycles (EXEC, RESP).
- Ordering: responses always in request order; no reordering.
- Backpressure: rsp_ready low holds RESP indefinitely; the FIFO keeps filling until full.
- Reset mid-operation: in-flight and queued requests are discarded; no response is issued for them.

Optional Feature:
- Macro: FPU_ISSUE_OPCHECK_EN.
- Defined:
  - An illegal opcode at the FIFO head is never driven to the FPU (fpu_op stays 4'hF).
  - In its EXEC cycle the entry is popped and the FSM goes to RESP with rsp_result=0, rsp_err=1.
  - rsp_err=0 for all legal ops.
- Undefined:
  - Illegal opcodes are issued as combinational ops; the FPU default returns 0.
  - rsp_err is tied 0.

Decomposition:
- Shared package fpu_pkg:
  - Opcode localparams: FP_ADD=0000, FP_SUB=0001, FP_MAX=0010, FP_MUL=0011, FP_MIN=0100, FP_ABS=0101, FP_NEG=0110, FP_FLOOR=1000, FP_CEIL=1001, FP_SIGN=1010, FP_IDLE=1111.
  - Function is_mul(op) and function is_legal(op).
  - FSM state enum.
- One sub-module, fpu_req_fifo: a parameterised synchronous FIFO of {tag, op, b, a} with async reset.

Test Plan:
- Single ADD: a=0x3F8000, b=0x400000, tag=3, accepted cycle 0 → rsp_valid cycle 3, rsp_tag=3, rsp_result equals the fpu_result sampled during EXEC; fpu_op=0000 for exactly one cycle.
- MUL with MUL_LAT=1: op=0011, tag=5 → fpu_op holds 0011 for 2 cycles, rsp_valid cycle 4, rsp_tag=5.
- Fill: push 5 requests with rsp_ready=0 → req_ready=0 after 4 queued plus 1 held in RESP; raising rsp_ready drains tags 0..4 in order, one response per 2 cycles.
- Backpressure: hold rsp_ready=0 for 10 cycles during RESP → rsp_result and rsp_tag stable, no FIFO pop.
- Async reset while in EXEC of a MUL → rsp_valid=0 and fpu_op=4'hF immediately; FIFO empty; no response emitted after release.
- op=1100, tag=7 with FPU_ISSUE_OPCHECK_EN defined → fpu_op never 1100, rsp_err=1, rsp_result=0, rsp_tag=7; without the macro → rsp_err=0, rsp_result=0.
